bcd_seq_converter: RTL and testbench

Parametrised, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It replaces the combinational 8-bit unrolled converter for wide operands and supports optional two's-complement input and a truncation flag. It feeds the seven-segment and display paths with registered, handshaked results so that conversion logic is off the CPU critical path.

---
 rtl/bcd_seq_converter.sv | 158 +++++++++++++++
 tb/tb_bcd_seq_converter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Optional two's-complement input; truncated results raise a sticky overflow flag.
module bcd_seq_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  negative,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_mag;
    logic [BW-1:0]     r_dig;
    logic              r_sign;
    logic              r_sticky;
    logic              r_busy;
    logic              r_done;
    logic [BW-1:0]     r_bcd;
    logic              r_negative;
    logic              r_overflow;

    logic              w_accept;
    logic              w_last;
    logic              w_neg_in;
    logic [WIDTH-1:0]  w_mag_in;
    logic [BW-1:0]     w_adj;
    logic [BW-1:0]     w_shift_dig;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and handshake decode
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_SHIFT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CW'(1)) begin
                    w_last       = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand magnitude; the most negative value wraps to 2^(WIDTH-1) unsigned
    always_comb begin
        w_neg_in = 1'b0;
        w_mag_in = binary;
        if ((SIGNED != 0) && binary[WIDTH-1]) begin
            w_neg_in = 1'b1;
            w_mag_in = ~binary + WIDTH'(1);
        end else begin
            w_neg_in = 1'b0;
            w_mag_in = binary;
        end
    end

    // Add-3 correction of every working digit, then the shifted digit vector
    always_comb begin
        w_adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_dig[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_dig[4*k +: 4] + 4'd3;
            end else begin
                w_adj[4*k +: 4] = r_dig[4*k +: 4];
            end
        end
        w_shift_dig = {w_adj[BW-2:0], r_mag[WIDTH-1]};
    end

    // Datapath: capture, shift, and result registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_mag      <= '0;
            r_dig      <= '0;
            r_sign     <= 1'b0;
            r_sticky   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_negative <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_mag    <= w_mag_in;
                r_dig    <= '0;
                r_sign   <= w_neg_in;
                r_sticky <= 1'b0;
                r_cnt    <= CW'(WIDTH);
                r_busy   <= 1'b1;
            end else if (r_state == ST_SHIFT) begin
                r_dig    <= w_shift_dig;
                r_mag    <= {r_mag[WIDTH-2:0], 1'b0};
                r_sticky <= r_sticky | w_adj[BW-1];
                r_cnt    <= r_cnt - CW'(1);
                // The bit leaving the top digit on the final shift still counts
                if (w_last) begin
                    r_bcd      <= w_shift_dig;
                    r_negative <= r_sign;
                    r_overflow <= r_sticky | w_adj[BW-1];
                    r_busy     <= 1'b0;
                end else begin
                    r_busy     <= 1'b1;
                end
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign negative = r_negative;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Bench for bcd_seq_converter: four parameterisations driven from directed vectors,
// checked by a scoreboard queue drained by an independent monitor.
module tb_bcd_seq_converter;

    typedef struct packed {
        logic [1:0]  id;
        logic [19:0] bcd;
        logic        neg;
        logic        ovf;
        logic [31:0] cyc;
    } exp_t;

    logic        clock;
    logic        resetn;
    logic [3:0]  st;
    logic [3:0]  dn;
    logic [3:0]  bz;
    logic [3:0]  ng;
    logic [3:0]  ov;
    logic [15:0] bin  [4];
    logic [19:0] bcdv [4];
    logic [11:0] bcd0;
    logic [19:0] bcd1;
    logic [11:0] bcd2;
    logic [7:0]  bcd3;

    exp_t        q[$];
    int          total;
    int          bad;
    logic [31:0] cyc;
    int          bcnt [4];
    logic [21:0] prev_out [4];
    logic        prev_rst;

    // id 0: 8-bit/3 digits, id 1: 16-bit/5 digits, id 2: 8-bit signed, id 3: 8-bit/2 digits
    bcd_seq_converter #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_b8 (
        .clock(clock), .resetn(resetn), .start(st[0]), .binary(bin[0][7:0]),
        .busy(bz[0]), .done(dn[0]), .bcd(bcd0), .negative(ng[0]), .overflow(ov[0]));
    bcd_seq_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_b16 (
        .clock(clock), .resetn(resetn), .start(st[1]), .binary(bin[1]),
        .busy(bz[1]), .done(dn[1]), .bcd(bcd1), .negative(ng[1]), .overflow(ov[1]));
    bcd_seq_converter #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_sgn (
        .clock(clock), .resetn(resetn), .start(st[2]), .binary(bin[2][7:0]),
        .busy(bz[2]), .done(dn[2]), .bcd(bcd2), .negative(ng[2]), .overflow(ov[2]));
    bcd_seq_converter #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) u_trn (
        .clock(clock), .resetn(resetn), .start(st[3]), .binary(bin[3][7:0]),
        .busy(bz[3]), .done(dn[3]), .bcd(bcd3), .negative(ng[3]), .overflow(ov[3]));

    assign bcdv[0] = {8'd0, bcd0};
    assign bcdv[1] = bcd1;
    assign bcdv[2] = {8'd0, bcd2};
    assign bcdv[3] = {12'd0, bcd3};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 32'd1;

    function automatic int wid(input int id);
        return (id == 1) ? 16 : 8;
    endfunction

    // Monitor: pops one expectation per done pulse and checks latency/busy/hold
    always @(negedge clock) begin
        exp_t e;
        if (!resetn) begin
            for (int i = 0; i < 4; i++) bcnt[i] = 0;
            prev_rst = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bz[i]) bcnt[i]++;
                if (dn[i]) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL spurious_done inst=%0d got bcd=%h expected no done", i, bcdv[i]);
                    end else begin
                        e = q.pop_front();
                        if (e.id != 2'(i)) begin
                            bad++;
                            $display("FAIL done_inst got=%0d expected=%0d", i, e.id);
                        end
                        total++;
                        if (bcdv[i] != e.bcd) begin
                            bad++;
                            $display("FAIL bcd inst=%0d got=%h expected=%h", i, bcdv[i], e.bcd);
                        end
                        total++;
                        if (ng[i] != e.neg || ov[i] != e.ovf) begin
                            bad++;
                            $display("FAIL flags inst=%0d got neg=%b ovf=%b expected neg=%b ovf=%b",
                                     i, ng[i], ov[i], e.neg, e.ovf);
                        end
                        total++;
                        if (cyc != e.cyc + 32'(wid(i)) + 32'd1) begin
                            bad++;
                            $display("FAIL latency inst=%0d got cyc=%0d expected cyc=%0d",
                                     i, cyc, e.cyc + 32'(wid(i)) + 32'd1);
                        end
                        total++;
                        if (bcnt[i] != wid(i)) begin
                            bad++;
                            $display("FAIL busy_len inst=%0d got=%0d expected=%0d", i, bcnt[i], wid(i));
                        end
                    end
                    bcnt[i] = 0;
                end else if (prev_rst) begin
                    total++;
                    if ({bcdv[i], ng[i], ov[i]} != prev_out[i]) begin
                        bad++;
                        $display("FAIL hold inst=%0d got=%h expected=%h", i,
                                 {bcdv[i], ng[i], ov[i]}, prev_out[i]);
                    end
                end
            end
            prev_rst = 1'b1;
        end
        for (int i = 0; i < 4; i++) prev_out[i] = {bcdv[i], ng[i], ov[i]};
    end

    task automatic issue(input int id, input logic [15:0] val,
                         input logic [19:0] eb, input logic en, input logic eo);
        exp_t e;
        e.id  = 2'(id);
        e.bcd = eb;
        e.neg = en;
        e.ovf = eo;
        e.cyc = cyc;
        st[id]  = 1'b1;
        bin[id] = val;
        q.push_back(e);
        @(negedge clock);
        st[id]  = 1'b0;
        bin[id] = 16'hA5A5;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bz != 4'd0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got pending=%0d expected=0", q.size());
            q.delete();
        end
    endtask

    task automatic wait_done(input int id);
        int n;
        n = 0;
        while (!dn[id] && n < 100) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (!dn[id]) begin
            bad++;
            $display("FAIL wait_done inst=%0d got done=0 expected done=1", id);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cyc    = 32'd0;
        resetn = 1'b0;
        st     = 4'd0;
        for (int i = 0; i < 4; i++) bin[i] = 16'd0;
        #23;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({bcdv[i], ng[i], ov[i], bz[i], dn[i]} != 24'd0) begin
                bad++;
                $display("FAIL reset_state inst=%0d got=%h expected=0", i,
                         {bcdv[i], ng[i], ov[i], bz[i], dn[i]});
            end
        end
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        issue(0, 16'd255, 20'h00255, 1'b0, 1'b0);
        drain();

        issue(1, 16'd65535, 20'h65535, 1'b0, 1'b0);
        drain();
        issue(1, 16'd0, 20'h00000, 1'b0, 1'b0);
        drain();
        issue(1, 16'd10000, 20'h10000, 1'b0, 1'b0);
        drain();
        issue(1, 16'd12345, 20'h12345, 1'b0, 1'b0);
        drain();

        issue(2, 16'h0080, 20'h00128, 1'b1, 1'b0);
        drain();
        issue(2, 16'h00FF, 20'h00001, 1'b1, 1'b0);
        drain();
        issue(2, 16'd127, 20'h00127, 1'b0, 1'b0);
        drain();

        issue(3, 16'd200, 20'h00000, 1'b0, 1'b1);
        drain();
        issue(3, 16'd99, 20'h00099, 1'b0, 1'b0);
        drain();
        issue(3, 16'd150, 20'h00050, 1'b0, 1'b1);
        drain();

        // Start during busy is ignored; start in the done cycle is accepted
        issue(0, 16'd42, 20'h00042, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        st[0]  = 1'b1;
        bin[0] = 16'd17;
        @(negedge clock);
        st[0]  = 1'b0;
        wait_done(0);
        issue(0, 16'd17, 20'h00017, 1'b0, 1'b0);
        drain();

        // Reset mid-conversion: outputs clear at once and no done appears
        st[0]  = 1'b1;
        bin[0] = 16'd153;
        @(negedge clock);
        st[0]  = 1'b0;
        repeat (2) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        total++;
        if ({bcdv[0], ng[0], ov[0], bz[0], dn[0]} != 24'd0) begin
            bad++;
            $display("FAIL reset_mid got=%h expected=0", {bcdv[0], ng[0], ov[0], bz[0], dn[0]});
        end
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (12) @(negedge clock);
        issue(0, 16'd73, 20'h00073, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
